// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the IF-stage fetch unit: default widths, reset PC,
// queue sizing helper and the per-cycle response classification.
package pc_fetch_unit_pkg;

    localparam int              ADDR_W_DEF   = 32;
    localparam int              DATA_W_DEF   = 32;
    localparam int              INST_B_DEF   = 4;
    localparam int              DEPTH_DEF    = 4;
    localparam logic [31:0]     RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_FILL,
        RESP_DROP,
        RESP_ERROR
    } resp_kind_t;

    // Occupancy counters must be able to hold DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch request, memory response and IF/ID output handshakes of the fetch unit.
interface pc_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              out_valid;
    logic [ADDR_W-1:0] out_pc;
    logic [DATA_W-1:0] out_inst;
    logic              out_ready;

    modport master (
        output req_valid, req_addr, out_valid, out_pc, out_inst,
        input  req_ready, resp_valid, resp_data, out_ready
    );

    modport slave (
        input  req_valid, req_addr, out_valid, out_pc, out_inst,
        output req_ready, resp_valid, resp_data, out_ready
    );
endinterface

// File: rtl/pc_fetch_unit_fetch_tag_queue.sv
// In-order ring of outstanding fetches: push at tail, fill at resp, pop at head.
// Each entry pairs a request PC with its returned instruction word.
module fetch_tag_queue
    import pc_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      push,
    input  logic [ADDR_W-1:0]         push_pc,
    input  logic                      fill,
    input  logic [DATA_W-1:0]         fill_data,
    input  logic                      pop,
    output logic                      head_valid,
    output logic [ADDR_W-1:0]         head_pc,
    output logic [DATA_W-1:0]         head_inst,
    output logic [cnt_w(DEPTH)-1:0]   cnt,
    output logic [cnt_w(DEPTH)-1:0]   pend
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];
    logic [DEPTH-1:0]  done;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  resp;
    logic [PTR_W-1:0]  tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            resp <= '0;
            tail <= '0;
            cnt  <= '0;
            pend <= '0;
            done <= '0;
        end else if (flush) begin
            head <= '0;
            resp <= '0;
            tail <= '0;
            cnt  <= '0;
            pend <= '0;
            done <= '0;
        end else begin
            if (push) begin
                done[tail] <= 1'b0;
                tail       <= tail + PTR_W'(1);
            end
            if (fill) begin
                done[resp] <= 1'b1;
                resp       <= resp + PTR_W'(1);
            end
            if (pop) begin
                done[head] <= 1'b0;
                head       <= head + PTR_W'(1);
            end
            cnt  <= cnt + CNT_W'(push) - CNT_W'(pop);
            pend <= pend + CNT_W'(push) - CNT_W'(fill);
        end
    end

    // Payload storage needs no reset: nothing is visible until its done bit is set.
    always_ff @(posedge clk) begin
        if (push && !flush) pc_mem[tail] <= push_pc;
        if (fill && !flush) inst_mem[resp] <= fill_data;
    end

    assign head_valid = done[head];
    assign head_pc    = done[head] ? pc_mem[head]   : '0;
    assign head_inst  = done[head] ? inst_mem[head] : '0;

endmodule

// File: rtl/pc_fetch_unit.sv
// IF-stage PC generator: issues sequential fetches, pairs responses with PCs and
// discards responses made stale by a redirect.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                INST_B   = INST_B_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int                DEPTH    = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    pc_fetch_unit_if.master   bus
);
    localparam int                CNT_W      = cnt_w(DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INST_B - 1));

    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  pend;
    logic [CNT_W:0]    occupancy;
    logic              req_fire;
    logic              push;
    logic              fill;
    logic              pop;
    logic              resp_used;
    resp_kind_t        resp_kind;

    // Stale fetches still in flight hold their slot until the memory answers them.
    assign occupancy     = {1'b0, cnt} + {1'b0, drop_cnt};
    assign bus.req_valid = rst_n && !stall && (occupancy < (CNT_W + 1)'(DEPTH));
    assign bus.req_addr  = pc;
    assign req_fire      = bus.req_valid && bus.req_ready;

    always_comb begin
        resp_kind = RESP_NONE;
        if (bus.resp_valid) begin
            if (drop_cnt != '0)  resp_kind = RESP_DROP;
            else if (pend != '0) resp_kind = RESP_FILL;
            else                 resp_kind = RESP_ERROR;
        end
    end

    assign resp_used = (resp_kind == RESP_FILL) || (resp_kind == RESP_DROP);
    assign push      = req_fire && !redirect;
    assign fill      = (resp_kind == RESP_FILL) && !redirect;
    assign pop       = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc & ALIGN_MASK;
        end else if (req_fire) begin
            pc <= pc + ADDR_W'(INST_B);
        end
    end

    // On redirect every pending fetch plus this cycle's request becomes stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (redirect) begin
            drop_cnt <= drop_cnt + pend + CNT_W'(req_fire) - CNT_W'(resp_used);
        end else if (resp_kind == RESP_DROP) begin
            drop_cnt <= drop_cnt - CNT_W'(1);
        end
    end

    fetch_tag_queue #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect),
        .push       (push),
        .push_pc    (pc),
        .fill       (fill),
        .fill_data  (bus.resp_data),
        .pop        (pop),
        .head_valid (bus.out_valid),
        .head_pc    (bus.out_pc),
        .head_inst  (bus.out_inst),
        .cnt        (cnt),
        .pend       (pend)
    );

    a_no_unexpected_resp : assert property (
        @(posedge clk) disable iff (!rst_n) resp_kind != RESP_ERROR
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; a second instance exercises PC wrap.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        w_rst_n;
    logic        w_stall;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    int          checks;
    int          errors;

    pc_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    pc_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) wbus ();

    pc_fetch_unit #(
        .ADDR_W(32), .DATA_W(32), .INST_B(4), .RESET_PC(32'h0), .DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .bus(bus)
    );

    pc_fetch_unit #(
        .ADDR_W(32), .DATA_W(32), .INST_B(4), .RESET_PC(32'hFFFF_FFF8), .DEPTH(4)
    ) dut_w (
        .clk(clk), .rst_n(w_rst_n), .stall(w_stall), .redirect(w_redirect),
        .redirect_pc(w_redirect_pc), .bus(wbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input int n);
        return 32'hA000_0000 + 32'(n);
    endfunction

    task automatic do_reset();
        rst_n           = 1'b0;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = '0;
        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.resp_data   = '0;
        bus.out_ready   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        bus.req_ready  = 1'b1;
        bus.resp_valid = 1'b0;
        bus.resp_data  = '0;
        bus.out_ready  = 1'b1;
        @(negedge clk); #1;
        checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid got %b want 0", bus.req_valid); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_pc got %h want 0", bus.out_pc); end
        checks++; if (bus.out_inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_inst got %h want 0", bus.out_inst); end
        checks++; if (bus.req_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_req_addr got %h want 0", bus.req_addr); end
        checks++; if (dut.drop_cnt !== 3'd0) begin errors++; $display("[TB] FAIL reset_drop_cnt got %0d want 0", dut.drop_cnt); end
    endtask

    task automatic test_stream();
        do_reset();
        bus.req_ready = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.req_valid !== 1'b1 || bus.req_addr !== 32'h0) begin errors++; $display("[TB] FAIL stream_first_req got v=%b a=%h want v=1 a=0", bus.req_valid, bus.req_addr); end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.resp_valid = 1'b1;
            bus.resp_data  = inst_of(k - 1);
            #1;
            checks++; if (bus.req_addr !== 32'(4 * k)) begin errors++; $display("[TB] FAIL stream_req_addr[%0d] got %h want %h", k, bus.req_addr, 32'(4 * k)); end
            if (k >= 2) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * (k - 2)) || bus.out_inst !== inst_of(k - 2)) begin
                    errors++;
                    $display("[TB] FAIL stream_out[%0d] got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", k, bus.out_valid, bus.out_pc, bus.out_inst, 32'(4 * (k - 2)), inst_of(k - 2));
                end
            end
        end
        @(negedge clk);
        stall          = 1'b1;
        bus.resp_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h14 || bus.out_inst !== inst_of(5)) begin errors++; $display("[TB] FAIL stream_last_out got v=%b pc=%h inst=%h want v=1 pc=14 inst=%h", bus.out_valid, bus.out_pc, bus.out_inst, inst_of(5)); end
        @(negedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_drained got %b want 0", bus.out_valid); end
    endtask

    task automatic test_full();
        do_reset();
        bus.req_ready = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checks++; if (bus.req_valid !== 1'b1 || bus.req_addr !== 32'(4 * k)) begin errors++; $display("[TB] FAIL full_req[%0d] got v=%b a=%h want v=1 a=%h", k, bus.req_valid, bus.req_addr, 32'(4 * k)); end
        end
        @(negedge clk);
        bus.resp_valid = 1'b1;
        bus.resp_data  = 32'hDEAD_0000;
        #1;
        checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_blocked got %b want 0", bus.req_valid); end
        @(negedge clk);
        bus.resp_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_inst !== 32'hDEAD_0000) begin errors++; $display("[TB] FAIL full_out got v=%b pc=%h inst=%h want v=1 pc=0 inst=dead0000", bus.out_valid, bus.out_pc, bus.out_inst); end
        checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_still_blocked got %b want 0", bus.req_valid); end
        @(negedge clk);
        bus.req_ready = 1'b0;
        #1;
        checks++; if (bus.req_valid !== 1'b1 || bus.req_addr !== 32'h10) begin errors++; $display("[TB] FAIL full_resume got v=%b a=%h want v=1 a=10", bus.req_valid, bus.req_addr); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_popped got %b want 0", bus.out_valid); end
    endtask

    task automatic test_redirect();
        do_reset();
        bus.req_ready = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.req_ready = 1'b0;
        redirect      = 1'b1;
        redirect_pc   = 32'h0000_0103;
        @(negedge clk);
        redirect       = 1'b0;
        bus.req_ready  = 1'b1;
        bus.resp_valid = 1'b1;
        bus.resp_data  = 32'h0000_0AAA;
        #1;
        checks++; if (bus.req_addr !== 32'h100) begin errors++; $display("[TB] FAIL redir_pc got %h want 100", bus.req_addr); end
        checks++; if (dut.drop_cnt !== 3'd2) begin errors++; $display("[TB] FAIL redir_drop_cnt got %0d want 2", dut.drop_cnt); end
        @(negedge clk);
        bus.req_ready = 1'b0;
        bus.resp_data = 32'h0000_0BBB;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_stale1_out got %b want 0", bus.out_valid); end
        @(negedge clk);
        bus.resp_data = 32'h0000_0CCC;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || dut.drop_cnt !== 3'd0) begin errors++; $display("[TB] FAIL redir_stale2 got v=%b drop=%0d want v=0 drop=0", bus.out_valid, dut.drop_cnt); end
        @(negedge clk);
        bus.resp_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100 || bus.out_inst !== 32'h0000_0CCC) begin errors++; $display("[TB] FAIL redir_target_out got v=%b pc=%h inst=%h want v=1 pc=100 inst=ccc", bus.out_valid, bus.out_pc, bus.out_inst); end
    endtask

    task automatic test_redirect_collide();
        do_reset();
        bus.req_ready = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        redirect       = 1'b1;
        redirect_pc    = 32'h0000_0200;
        bus.resp_valid = 1'b1;
        bus.resp_data  = 32'h0000_1111;
        @(negedge clk);
        redirect       = 1'b0;
        bus.req_ready  = 1'b0;
        bus.resp_data  = 32'h0000_2222;
        #1;
        checks++; if (dut.drop_cnt !== 3'd1) begin errors++; $display("[TB] FAIL collide_drop_cnt got %0d want 1", dut.drop_cnt); end
        checks++; if (bus.req_addr !== 32'h200) begin errors++; $display("[TB] FAIL collide_pc got %h want 200", bus.req_addr); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL collide_out got %b want 0", bus.out_valid); end
        @(negedge clk);
        bus.resp_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || dut.drop_cnt !== 3'd0) begin errors++; $display("[TB] FAIL collide_drained got v=%b drop=%0d want v=0 drop=0", bus.out_valid, dut.drop_cnt); end
    endtask

    task automatic test_stall();
        do_reset();
        bus.req_ready = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            bus.resp_valid = (i == 1) || (i == 2);
            bus.resp_data  = inst_of(100 + i);
            #1;
            checks++; if (bus.req_valid !== 1'b0 || bus.req_addr !== 32'h8) begin errors++; $display("[TB] FAIL stall_hold[%0d] got v=%b a=%h want v=0 a=8", i, bus.req_valid, bus.req_addr); end
            if (i == 2) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_inst !== inst_of(101)) begin errors++; $display("[TB] FAIL stall_out0 got v=%b pc=%h inst=%h want v=1 pc=0 inst=%h", bus.out_valid, bus.out_pc, bus.out_inst, inst_of(101)); end
            end
            if (i == 3) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h4 || bus.out_inst !== inst_of(102)) begin errors++; $display("[TB] FAIL stall_out1 got v=%b pc=%h inst=%h want v=1 pc=4 inst=%h", bus.out_valid, bus.out_pc, bus.out_inst, inst_of(102)); end
            end
        end
        @(negedge clk);
        stall = 1'b0;
        bus.req_ready = 1'b0;
        #1;
        checks++; if (bus.req_valid !== 1'b1 || bus.req_addr !== 32'h8) begin errors++; $display("[TB] FAIL stall_resume got v=%b a=%h want v=1 a=8", bus.req_valid, bus.req_addr); end
    endtask

    task automatic test_wrap();
        w_stall         = 1'b0;
        w_redirect      = 1'b0;
        w_redirect_pc   = '0;
        wbus.req_ready  = 1'b1;
        wbus.resp_valid = 1'b0;
        wbus.resp_data  = '0;
        wbus.out_ready  = 1'b0;
        @(negedge clk);
        w_rst_n = 1'b1;
        #1;
        checks++; if (wbus.req_addr !== 32'hFFFF_FFF8) begin errors++; $display("[TB] FAIL wrap_addr0 got %h want fffffff8", wbus.req_addr); end
        @(negedge clk);
        wbus.resp_valid = 1'b1;
        wbus.resp_data  = 32'h0000_5A5A;
        #1;
        checks++; if (wbus.req_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_addr1 got %h want fffffffc", wbus.req_addr); end
        @(negedge clk);
        wbus.resp_valid = 1'b0;
        #1;
        checks++; if (wbus.req_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_addr2 got %h want 0", wbus.req_addr); end
        checks++; if (wbus.out_valid !== 1'b1 || wbus.out_pc !== 32'hFFFF_FFF8) begin errors++; $display("[TB] FAIL wrap_out got v=%b pc=%h want v=1 pc=fffffff8", wbus.out_valid, wbus.out_pc); end
        #1;
        w_rst_n = 1'b0;
        #1;
        checks++; if (wbus.req_valid !== 1'b0 || wbus.out_valid !== 1'b0 || wbus.out_pc !== 32'h0 || wbus.out_inst !== 32'h0) begin errors++; $display("[TB] FAIL wrap_async_reset got rv=%b ov=%b pc=%h inst=%h want all 0", wbus.req_valid, wbus.out_valid, wbus.out_pc, wbus.out_inst); end
        checks++; if (dut_w.cnt !== 3'd0 || wbus.req_addr !== 32'hFFFF_FFF8) begin errors++; $display("[TB] FAIL wrap_reset_state got cnt=%0d addr=%h want cnt=0 addr=fffffff8", dut_w.cnt, wbus.req_addr); end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        w_rst_n = 1'b0;
        w_stall = 1'b0;
        w_redirect = 1'b0;
        w_redirect_pc = '0;
        wbus.req_ready = 1'b0;
        wbus.resp_valid = 1'b0;
        wbus.resp_data = '0;
        wbus.out_ready = 1'b0;
        $display("[TB] starting pc_fetch_unit bench");
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_redirect_collide();
        test_stall();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
